// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - eight-digit seven-segment scan controller with two-requester update port
//
// Purpose:
//   Time-multiplexes a 32-bit display register onto eight common-anode
//   seven-segment digits. Two requesters offer new display values through
//   a valid/ready handshake arbitrated round-robin. An accepted value waits
//   in a pending register and is committed only at the end of a full scan
//   frame, so the displayed value never changes mid-frame.
//
// Parameters:
//   SCAN_DIV     clock cycles each digit stays lit (1..65535)
//
// Optional feature macro:
//   SEG_LZB_EN   when defined, blank leading-zero digits (digit 0 never blanked)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   req0_valid   requester 0 offers req0_data
//   req0_data    requester 0 value, nibble k shown on digit k
//   req0_ready   requester 0 value accepted when valid & ready
//   req1_valid   requester 1 offers req1_data
//   req1_data    requester 1 value
//   req1_ready   requester 1 value accepted when valid & ready
//   seg_n        active-low segments {a,b,c,d,e,f,g,dp}
//   an_n         active-low one-hot digit enable
//   frame_start  one-cycle pulse on the first cycle of each scan frame
//   pend         an accepted value is waiting for the next commit

module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n,
  output logic        frame_start,
  output logic        pend
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PTERM = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    digit;
  logic [31:0]   disp_reg;
  logic [31:0]   pend_reg;
  logic          ptr;        // 0 favours req0, 1 favours req1

  logic          term;
  logic          frame_end;
  logic          gnt1;
  logic          xfer;
  logic [3:0]    nib;
  logic          blank;

  // Active-high segment pattern {a,b,c,d,e,f,g,dp}; dp is never lit.
  function automatic logic [7:0] hex_pattern(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hFC;
      4'h1: p = 8'h60;
      4'h2: p = 8'hDA;
      4'h3: p = 8'hF2;
      4'h4: p = 8'h66;
      4'h5: p = 8'hB6;
      4'h6: p = 8'hBE;
      4'h7: p = 8'hE0;
      4'h8: p = 8'hFE;
      4'h9: p = 8'hF6;
      4'hA: p = 8'hEE;
      4'hB: p = 8'h3E;
      4'hC: p = 8'h9C;
      4'hD: p = 8'h7A;
      4'hE: p = 8'h9E;
      4'hF: p = 8'h8E;
      default: p = 8'h00;
    endcase
    return p;
  endfunction

  assign term      = (presc == PTERM);
  // Last dwell cycle of digit 7: the only point where the display may change.
  assign frame_end = term && (digit == 3'd7);

  // req1 wins when it is the only requester or when both ask and it is favoured.
  assign gnt1       = req1_valid && (!req0_valid || ptr);
  assign req0_ready = !pend && req0_valid && !gnt1;
  assign req1_ready = !pend && gnt1;
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc       <= '0;
      digit       <= 3'd0;
      disp_reg    <= 32'd0;
      pend_reg    <= 32'd0;
      pend        <= 1'b0;
      ptr         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (term) begin
        presc <= '0;
        digit <= digit + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end

      frame_start <= frame_end;

      // Transfer and commit are mutually exclusive: ready is low while pend is set.
      if (xfer) begin
        pend_reg <= gnt1 ? req1_data : req0_data;
        pend     <= 1'b1;
        ptr      <= ~gnt1;
      end else if (frame_end && pend) begin
        disp_reg <= pend_reg;
        pend     <= 1'b0;
      end
    end
  end

  assign nib  = disp_reg[{digit, 2'b00} +: 4];
  assign an_n = ~(8'b0000_0001 << digit);

`ifdef SEG_LZB_EN
  logic [31:0] upper;
  // Nibbles digit..7 shifted down; all zero means this digit is a leading zero.
  assign upper = disp_reg >> {digit, 2'b00};
  assign blank = (digit != 3'd0) && (upper == 32'd0);
`else
  assign blank = 1'b0;
`endif

  assign seg_n = blank ? 8'hFF : ~hex_pattern(nib);

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles each digit is lit (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 SHALL have port req0_valid  input  1  requester 0 offers a display value.
REQ-005 SHALL have port req0_data  input  32  requester 0 value, 8 hex nibbles, nibble k shown on digit k.
REQ-006 SHALL have port req0_ready  output  1  requester 0 value accepted this cycle when valid&ready.
REQ-007 SHALL have ports req1_valid/req1_data/req1_ready with identical widths and meaning for requester 1.
REQ-008 SHALL have port seg_n  output  8  active-low segments {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp.
REQ-009 SHALL have port an_n  output  8  active-low one-hot digit enable, bit k = digit k.
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse at start of each scan frame.
REQ-011 SHALL have port pend  output  1  high while an accepted value awaits commit.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; digit index (0..7) SHALL increment on prescaler terminal count, wrapping 7->0.
REQ-013 an_n SHALL equal ~(1<<digit) combinationally from the digit register; exactly one bit low at all times.
REQ-014 seg_n SHALL equal the bitwise inverse of the active-high pattern for nibble[digit] of the display register: 0 FC,1 60,2 DA,3 F2,4 66,5 B6,6 BE,7 E0,8 FE,9 F6,A EE,B 3E,C 9C,D 7A,E 9E,F 8E (dp always off).
REQ-015 Arbiter SHALL be round-robin over two requesters with a one-bit priority pointer; grant to the single valid requester, or to the pointer's favoured one when both valid.
REQ-016 reqX_ready SHALL be high only when pend=0 and requester X is granted; at most one ready high per cycle.
REQ-017 On a transfer the data SHALL be captured into the pending register, pend SHALL go high next cycle, and the pointer SHALL favour the other requester.
REQ-018 Commit SHALL occur on the cycle where prescaler is terminal and digit=7: if pend=1, display register <= pending register and pend <= 0; if pend=0, display register unchanged.
REQ-019 No transfer SHALL occur in the commit cycle when pend=1 (ready low); a transfer is allowed in the cycle after pend clears.
REQ-020 Displayed value SHALL never change mid-frame (no tearing); latency from transfer to display is 1..8*SCAN_DIV cycles.
REQ-021 frame_start SHALL be a registered pulse, high exactly the first cycle digit=0 after a 7->0 wrap; not asserted out of reset.
REQ-022 With SCAN_DIV=1, digit SHALL advance every cycle and commit SHALL occur every 8 cycles.
REQ-023 valid deasserted before ready SHALL leave all state except the arbiter grant unchanged; data need not be held stable by this block's contract beyond the transfer cycle.

Reset
REQ-024 While rst=0: prescaler 0, digit 0, display register 0, pending register 0, pend 0, pointer favours req0, frame_start 0.
REQ-025 Outputs in reset SHALL be an_n=8'hFE, seg_n=8'h03, req0_ready=0 unless req0_valid... (ready follows REQ-016 combinationally), pend=0.
REQ-026 Reset mid-frame SHALL discard any pending value; scanning restarts at digit 0 with a full SCAN_DIV dwell after release.

Configuration
REQ-027 Macro SEG_LZB_EN SHALL enable leading-zero blanking: digit k (k>=1) outputs seg_n=8'hFF when nibbles k..7 of the display register are all zero; digit 0 never blanked; an_n unaffected.
REQ-028 Without SEG_LZB_EN all eight digits SHALL show their nibble, including leading zeros.

Verification (SCAN_DIV=4)
REQ-029 Reset release, no requests -> an_n cycles FE,FD,...,7F each held 4 cycles, seg_n=03 throughout, frame_start pulse every 32 cycles.
REQ-030 req0 sends 0x1234ABCD mid-frame -> ready high one cycle, pend=1 until next commit, then digit0 seg_n=~8'h7A (D), digit7 seg_n=~8'h60 (1).
REQ-031 Both valid every cycle with distinct data -> grants alternate req0, req1, req0 across successive commits; never both ready.
REQ-032 Valid held while pend=1 -> ready stays low through commit cycle, rises the cycle after pend clears.
REQ-033 rst pulsed low while pend=1 at digit 5 -> pend=0, display 0, an_n=FE immediately (asynchronously).
REQ-034 SEG_LZB_EN defined, value 0x00000A00 -> digits 3..7 seg_n=FF, digit2 seg_n=~EE, digits 0,1 seg_n=03; undefined -> digits 3..7 seg_n=03.
